enc_player: RTL and testbench

Encoder event replayer: consumes the timestamped edge stream produced by the encoder capture path (64-bit counter value plus logic state per edge) and regenerates the encoder waveform on `enc_out`. Each edge is driven when the shared free-running counter reaches its timestamp. It sits on the PL side beside the capture block and shares its `counter_in`. It is used for loopback self-test and for driving simulated encoder signals into the stage under test.

---
 rtl/enc_pkg.sv | 22 ++
 rtl/enc_evt_fifo.sv | 48 ++++
 rtl/enc_player.sv | 81 ++++++++
 tb/tb_enc_player.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and wrap-safe timestamp helpers for the encoder capture/replay path.
package enc_pkg;
    localparam int TS_W = 64;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic            state;
    } enc_evt_t;

    // Due when the counter is at or past ts, modulo 2^64.
    function automatic logic ts_due(input logic [TS_W-1:0] now, input logic [TS_W-1:0] ts);
        logic [TS_W-1:0] diff;
        diff = now - ts;
        return ~diff[TS_W-1];
    endfunction

    function automatic logic ts_late(input logic [TS_W-1:0] now, input logic [TS_W-1:0] ts);
        logic [TS_W-1:0] diff;
        diff = now - ts;
        return ~diff[TS_W-1] && (diff != '0);
    endfunction
endpackage

// File: rtl/enc_evt_fifo.sv
// Synchronous event FIFO; head is presented combinationally from the read pointer.
module enc_evt_fifo
    import enc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   push_i,
    input  enc_evt_t               din_i,
    input  logic                   pop_i,
    output enc_evt_t               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    enc_evt_t          mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign level_o = cnt_q;
    assign cnt_d   = cnt_q + LW'(do_push) - LW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/enc_player.sv
// Encoder event replayer: drives each buffered edge when the shared counter reaches its timestamp.
module enc_player
    import enc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int LATE_W = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [TS_W-1:0]        counter_in,
    input  logic [TS_W-1:0]        s_axis_tdata,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic                   enc_out,
    output logic                   late,
    output logic [LATE_W-1:0]      late_count,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   clear
);
    enc_evt_t          head, din;
    logic              full, empty, accept, fire, is_late;
    logic              rdy_q;
    logic              enc_q, enc_d, late_q, late_d;
    logic [LATE_W-1:0] lcnt_q, lcnt_d;
    logic              unused_tlast;

    assign unused_tlast  = s_axis_tlast;
    // rdy_q keeps tready low until the first edge after reset release.
    assign s_axis_tready = rdy_q && !full && !areset;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign din           = '{ts: s_axis_tdata, state: s_axis_tuser};
    assign fire          = !empty && ts_due(counter_in, head.ts);
    assign is_late       = fire && ts_late(counter_in, head.ts);

    enc_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .areset  (areset),
        .push_i  (accept),
        .din_i   (din),
        .pop_i   (fire),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_comb begin
        enc_d  = enc_q;
        late_d = late_q;
        lcnt_d = lcnt_q;
        if (fire) enc_d = head.state;
        // clear wins over a same-cycle late increment
        if (clear) begin
            late_d = 1'b0;
            lcnt_d = '0;
        end else if (is_late) begin
            late_d = 1'b1;
            if (lcnt_q != '1) lcnt_d = lcnt_q + LATE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rdy_q  <= 1'b0;
            enc_q  <= 1'b0;
            late_q <= 1'b0;
            lcnt_q <= '0;
        end else begin
            rdy_q  <= 1'b1;
            enc_q  <= enc_d;
            late_q <= late_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign enc_out    = enc_q;
    assign late       = late_q;
    assign late_count = lcnt_q;
endmodule

// File: tb/tb_enc_player.sv
// Bench for enc_player: queue-based reference model checked every cycle, plus directed scenarios.
module tb_enc_player;
    localparam int DEPTH  = 8;
    localparam int LATE_W = 4;
    localparam int LMAX   = (1 << LATE_W) - 1;

    typedef struct packed {
        logic [63:0] ts;
        logic        st;
    } ev_t;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic [63:0]       counter_in = 64'd0;
    logic [63:0]       s_axis_tdata = 64'd0;
    logic              s_axis_tuser = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic              enc_out;
    logic              late;
    logic [LATE_W-1:0] late_count;
    logic [3:0]        level;
    logic              clear = 1'b0;

    always #5 clk = ~clk;

    enc_player #(.DEPTH(DEPTH), .LATE_W(LATE_W)) dut (
        .clk           (clk),
        .areset        (areset),
        .counter_in    (counter_in),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .enc_out       (enc_out),
        .late          (late),
        .late_count    (late_count),
        .level         (level),
        .clear         (clear)
    );

    // Reference model state
    ev_t         m_q[$];
    logic        m_enc;
    logic        m_late;
    int          m_cnt;
    bit          m_rdy_en;
    logic [63:0] acc_cnt;
    int          checks = 0;
    int          errors = 0;

    function automatic bit m_ready();
        return !areset && m_rdy_en && (m_q.size() < DEPTH);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_enc    = 1'b0;
        m_late   = 1'b0;
        m_cnt    = 0;
        m_rdy_en = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // One clock: sample inputs, advance the model at the edge, then advance the counter.
    task automatic step();
        bit          acc, clr, lt;
        logic [63:0] c, d;
        ev_t         e;
        acc  = s_axis_tvalid && m_ready();
        clr  = clear;
        c    = counter_in;
        e.ts = s_axis_tdata;
        e.st = s_axis_tuser;
        @(posedge clk);
        if (areset) begin
            m_reset();
        end else begin
            lt = 1'b0;
            if (m_q.size() != 0) begin
                d = c - m_q[0].ts;
                if (d < 64'h8000_0000_0000_0000) begin
                    m_enc = m_q[0].st;
                    lt    = (d != 64'd0);
                    void'(m_q.pop_front());
                end
            end
            if (clr) begin
                m_late = 1'b0;
                m_cnt  = 0;
            end else if (lt) begin
                m_late = 1'b1;
                if (m_cnt < LMAX) m_cnt++;
            end
            if (acc) begin
                m_q.push_back(e);
                acc_cnt = c;
            end
            m_rdy_en = 1'b1;
        end
        #1 counter_in = counter_in + 64'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input logic [63:0] target);
        for (int i = 0; i < 1000; i++) begin
            if (counter_in == target) return;
            step();
        end
        timeout("run_until");
    endtask

    task automatic push(input logic [63:0] ts, input logic st);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = ts;
        s_axis_tuser  = st;
        for (int i = 0; i < 200; i++) begin
            if (m_ready()) begin
                step();
                s_axis_tvalid = 1'b0;
                return;
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        timeout("push");
    endtask

    task automatic set_reset(input logic v);
        areset = v;
        if (v) m_reset();
        #1;
    endtask

    always @(negedge clk) begin
        chk("enc_out", enc_out, m_enc);
        chk("late", late, m_late);
        chk("late_count", late_count, m_cnt);
        chk("level", level, m_q.size());
        chk("tready", s_axis_tready, m_ready());
    end

    initial begin
        logic [63:0] base, c;
        m_reset();
        counter_in = 64'd100;
        step();
        step();
        chk("rst_enc", enc_out, 0);
        chk("rst_level", level, 0);
        chk("rst_tready", s_axis_tready, 0);
        set_reset(1'b0);
        chk("rel_tready_lo", s_axis_tready, 0);
        step();
        chk("rel_tready_hi", s_axis_tready, 1);

        // basic toggle
        push(64'd200, 1'b1);
        push(64'd210, 1'b0);
        push(64'd215, 1'b1);
        run_until(64'd200); chk("t1_200", enc_out, 0);
        step();             chk("t1_201", enc_out, 1);
        run_until(64'd210); chk("t1_210", enc_out, 1);
        step();             chk("t1_211", enc_out, 0);
        run_until(64'd215); chk("t1_215", enc_out, 0);
        step();             chk("t1_216", enc_out, 1);
        chk("t1_late", late, 0);
        chk("t1_level", level, 0);

        // late events
        counter_in = 64'd500;
        push(64'd400, 1'b1);
        push(64'd450, 1'b0);
        chk("t2_502", enc_out, 1);
        step();
        chk("t2_503", enc_out, 0);
        chk("t2_cnt", late_count, 2);
        chk("t2_late", late, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t2_clr_late", late, 0);
        chk("t2_clr_cnt", late_count, 0);

        // full buffer
        base = counter_in;
        for (int i = 0; i < 8; i++) push(base + 64'd50 + 64'(i), (i % 2) == 0);
        chk("t3_level", level, 8);
        chk("t3_tready", s_axis_tready, 0);
        push(base + 64'd58, 1'b0);
        chk("t3_acc9", acc_cnt, base + 64'd51);
        run(20);
        chk("t3_drain", level, 0);
        chk("t3_late", late_count, 0);
        chk("t3_enc", enc_out, 0);

        // counter wrap
        counter_in = 64'hFFFF_FFFF_FFFF_FFFD;
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        push(64'd1, 1'b0);
        chk("t4_ff", enc_out, 0);
        step(); chk("t4_0", enc_out, 1);
        step(); chk("t4_1", enc_out, 1);
        step(); chk("t4_2", enc_out, 0);
        chk("t4_late", late, 0);

        // reset mid-operation
        c = counter_in;
        push(c + 64'd1, 1'b1);
        for (int i = 0; i < 4; i++) push(c + 64'd100 + 64'(i), 1'b0);
        chk("t5_enc", enc_out, 1);
        chk("t5_level", level, 4);
        set_reset(1'b1);
        chk("t5_rst_enc", enc_out, 0);
        chk("t5_rst_level", level, 0);
        chk("t5_rst_tready", s_axis_tready, 0);
        step();
        step();
        set_reset(1'b0);
        chk("t5_rel_tready", s_axis_tready, 0);
        run(120);
        chk("t5_stale_enc", enc_out, 0);
        chk("t5_stale_level", level, 0);

        // redundant and simultaneous push/pop
        c = counter_in;
        push(c + 64'd1, 1'b1);
        run(2);
        chk("t6_enc", enc_out, 1);
        push(counter_in + 64'd1, 1'b1);
        run(2);
        chk("t6_red_enc", enc_out, 1);
        chk("t6_red_level", level, 0);
        c = counter_in;
        push(c + 64'd1, 1'b0);
        chk("t6_lvl_a", level, 1);
        push(c + 64'd100, 1'b1);
        chk("t6_lvl_b", level, 1);
        chk("t6_enc_b", enc_out, 0);
        run(110);

        // late counter saturation
        for (int i = 0; i < 20; i++) push(counter_in - 64'd100, i[0]);
        run(3);
        chk("t7_sat", late_count, LMAX);
        chk("t7_late", late, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                set_reset(1'b1);
                run($urandom_range(1, 2));
                set_reset(1'b0);
            end
            s_axis_tvalid = ($urandom_range(0, 2) != 0);
            s_axis_tdata  = counter_in + 64'($urandom_range(0, 30)) - 64'd8;
            s_axis_tuser  = 1'($urandom_range(0, 1));
            clear         = ($urandom_range(0, 63) == 0);
            step();
        end
        s_axis_tvalid = 1'b0;
        clear = 1'b0;
        run(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
